xor_stream_cipher: RTL
======================

Name: xor_stream_cipher

Overview:
- Streaming successor to the fixed 32-bit-key / 512-bit-message XOR encryptor.
- Loads a key of KEY_WORDS words of DATA_W bits each, then encrypts a message of run-time length, one DATA_W word per beat.
- Each message word is XORed with a repeating key; the message is never buffered in full.
- Sits between an upstream serializer/deserializer stage and the output serializer; all interfaces use valid/ready handshakes.

Parameters:
- DATA_W, 8, width of one message/key word.
- KEY_WORDS, 4, key length in words (key bits = DATA_W*KEY_WORDS).
- MAX_LEN, 64, maximum message length in beats.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; not to be overridden).

Ports:
- iClk  input  1  clock.
- iRst  input  1  synchronous reset, active-high.
- iEn  input  1  global enable; when low, all state and outputs hold.
- iKey_valid  input  1  key word valid.
- iKey_data  input  DATA_W  key word; word 0 first.
- oKey_ready  output  1  key word accepted when high with iKey_valid.
- oKey_loaded  output  1  a complete key is held.
- iStart  input  1  request to start a message (sampled in IDLE only).
- iMsg_len  input  LEN_W  message length in beats; latched on start.
- oBusy  output  1  state is not IDLE.
- oErr  output  1  1-cycle pulse: start rejected.
- iIn_valid  input  1  plaintext word valid.
- iIn_data  input  DATA_W  plaintext word.
- oIn_ready  output  1  plaintext word accepted.
- oOut_valid  output  1  ciphertext word valid.
- oOut_data  output  DATA_W  ciphertext word.
- iOut_ready  input  1  downstream accepts.
- oFirst  output  1  qualifies the first ciphertext beat of a message.
- oLast  output  1  qualifies the last ciphertext beat of a message.
- oDone  output  1  1-cycle pulse when the last beat is accepted downstream.

Behaviour:
- Reset: all outputs 0, state IDLE, key store and working key 0, oKey_loaded 0, all counters 0.
- iEn low: no handshake completes; all registers hold; oOut_valid and oOut_data are held.
- FSM states and transitions:
  - IDLE: oKey_ready=1.
    - A key beat writes word key_cnt, then increments key_cnt.
    - When word KEY_WORDS-1 is written: key_cnt wraps to 0 and oKey_loaded is set.
    - Any key write while oKey_loaded=1 clears oKey_loaded; it is set again only when a full key has been written.
    - On iStart with oKey_loaded=1 and 1<=iMsg_len<=MAX_LEN: latch len, copy key store to working key, kidx=0, beat=0, go to RUN.
    - Otherwise iStart pulses oErr for one cycle and the state stays IDLE.
  - RUN: oKey_ready=0.
    - oIn_ready = !oOut_valid || iOut_ready (one-entry output register, full throughput).
    - Accepted beat: oOut_data <= iIn_data ^ working_key[kidx], registered with 1-cycle latency; oOut_valid <= 1.
    - Accepted beat also sets oFirst <= (beat==0) and oLast <= (beat==len-1).
    - kidx increments and wraps KEY_WORDS-1 -> 0; beat increments.
    - Accepting the beat with beat==len-1 moves the state to DRAIN.
  - DRAIN: oIn_ready=0. When oOut_valid && iOut_ready: oOut_valid=0, oDone pulses, state returns to IDLE.
- In RUN, an output accepted with no new input drops oOut_valid.
- A held output (iOut_ready=0) keeps data, oFirst and oLast stable.
- Key packing: word i occupies bits [i*DATA_W +: DATA_W].
- len==1: oFirst and oLast are asserted on the same beat.
- Mid-operation reset: returns to IDLE, clears the key store, and drops oOut_valid on the next edge.
- iStart outside IDLE is ignored; no oErr.

Optional Feature:
- Macro XOR_KEY_EVOLVE_EN.
- When defined: on the beat where kidx wraps to 0, the working key (not the key store) rotates left by 1 bit across its full DATA_W*KEY_WORDS width. The rotation takes effect from the next beat.
- Each message restarts from the stored key.
- When not defined: the working key is constant for the whole message.

Decomposition:
- Package xor_cipher_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - default parameter constants;
  - a rotl helper function.
- Sub-module xor_key_store: key write port, key_cnt, oKey_loaded, stored-key output.
- The top holds the FSM, working key, counters and output register.

Test Plan:
- Key 0x11,0x22,0x33,0x44; len=6; input 0x00..0x05 -> output 0x11,0x23,0x31,0x47,0x15,0x27; oFirst on beat 0, oLast on beat 5, oDone one cycle after the last handshake.
- Same stream with iOut_ready held low for 3 cycles mid-message -> no loss or duplication; data/oFirst/oLast stable while stalled; oIn_ready low while the output is held.
- iStart with len=0, with len=MAX_LEN+1, and with no key loaded -> oErr single pulse each time, oBusy stays 0.
- Reset asserted during beat 3 of 6 -> next cycle oOut_valid=0, oBusy=0, oKey_loaded=0; a new key plus message then completes correctly.
- len=1, input 0xAB with key above -> output 0xBA with oFirst=oLast=1, then oDone.
- XOR_KEY_EVOLVE_EN: first test repeated -> beats 4,5 give 0x26,0x41 (working key 0x88664422); a second message restarts at 0x11.

Source files
------------

// File: rtl/xor_cipher_pkg.sv
// Shared types, default sizes and helpers for the XOR stream cipher.
package xor_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int XC_DATA_W    = 8;
  localparam int XC_KEY_WORDS = 4;
  localparam int XC_MAX_LEN   = 64;

  // Widest key the rotate helper can handle.
  localparam int ROT_MAX_W = 256;

  // Rotate the low w bits of v left by one; bits at and above w come back as 0.
  function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v,
                                                 input int unsigned w);
    logic [ROT_MAX_W-1:0] mask;
    logic [ROT_MAX_W-1:0] msb;
    mask = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
    msb  = (v >> (w - 1)) & ROT_MAX_W'(1);
    return ((v << 1) & mask) | msb;
  endfunction

endpackage

// File: rtl/xor_key_store.sv
// Key store: collects KEY_WORDS words (word 0 first) and flags a complete key.
module xor_key_store
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W    = XC_DATA_W,
  parameter int KEY_WORDS = XC_KEY_WORDS
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        wr_i,
  input  logic [DATA_W-1:0]           wr_data_i,
  output logic [DATA_W*KEY_WORDS-1:0] key_o,
  output logic                        loaded_o
);

  localparam int KCNT_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  logic [DATA_W-1:0] words_q [KEY_WORDS];
  logic [KCNT_W-1:0] cnt_q, cnt_d;
  logic              loaded_q, loaded_d;

  // Next write slot and completeness flag; any partial rewrite invalidates the key.
  always_comb begin
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    if (wr_i) begin
      if (cnt_q == KCNT_W'(KEY_WORDS - 1)) begin
        cnt_d    = '0;
        loaded_d = 1'b1;
      end else begin
        cnt_d    = cnt_q + KCNT_W'(1);
        loaded_d = 1'b0;
      end
    end
  end

  // Key words, write pointer and loaded flag; reset wipes the stored key.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      for (int i = 0; i < KEY_WORDS; i++) words_q[i] <= '0;
    end else if (en_i) begin
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      if (wr_i) words_q[cnt_q] <= wr_data_i;
    end
  end

  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_pack
    assign key_o[g*DATA_W +: DATA_W] = words_q[g];
  end

  assign loaded_o = loaded_q;

endmodule

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: message words XORed with a repeating key, one word per beat.
// Optional build macro XOR_KEY_EVOLVE_EN: the working key rotates left by one bit
// each time the key index wraps, restarting from the stored key on every message.
module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W    = XC_DATA_W,
  parameter int KEY_WORDS = XC_KEY_WORDS,
  parameter int MAX_LEN   = XC_MAX_LEN,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iKey_valid,
  input  logic [DATA_W-1:0] iKey_data,
  output logic              oKey_ready,
  output logic              oKey_loaded,
  input  logic              iStart,
  input  logic [LEN_W-1:0]  iMsg_len,
  output logic              oBusy,
  output logic              oErr,
  input  logic              iIn_valid,
  input  logic [DATA_W-1:0] iIn_data,
  output logic              oIn_ready,
  output logic              oOut_valid,
  output logic [DATA_W-1:0] oOut_data,
  input  logic              iOut_ready,
  output logic              oFirst,
  output logic              oLast,
  output logic              oDone
);

  localparam int KEY_BITS = DATA_W * KEY_WORDS;
  localparam int KCNT_W   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [KCNT_W-1:0]   kidx_q, kidx_d;
  logic [KEY_BITS-1:0] wkey_q, wkey_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic [KEY_BITS-1:0] store_key;
  logic                key_loaded;
  logic                key_wr;
  logic                in_fire;
  logic                out_fire;
  logic                len_ok;
  logic [DATA_W-1:0]   wkey_w [KEY_WORDS];

  assign oKey_ready = (state_q == IDLE);
  assign oIn_ready  = (state_q == RUN) && (!out_valid_q || iOut_ready);
  assign oBusy      = (state_q != IDLE);
  assign key_wr     = iKey_valid && oKey_ready;
  assign in_fire    = iIn_valid && oIn_ready;
  assign out_fire   = out_valid_q && iOut_ready;
  assign len_ok     = (iMsg_len != '0) && (iMsg_len <= LEN_W'(MAX_LEN));

  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_wkey
    assign wkey_w[g] = wkey_q[g*DATA_W +: DATA_W];
  end

  xor_key_store #(
    .DATA_W    (DATA_W),
    .KEY_WORDS (KEY_WORDS)
  ) u_key_store (
    .clk_i     (iClk),
    .rst_i     (iRst),
    .en_i      (iEn),
    .wr_i      (key_wr),
    .wr_data_i (iKey_data),
    .key_o     (store_key),
    .loaded_o  (key_loaded)
  );

  // Next-state logic: start/error in IDLE, beat encryption in RUN, final drain.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_d      = beat_q;
    kidx_d      = kidx_q;
    wkey_d      = wkey_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    first_d     = first_q;
    last_d      = last_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          if (key_loaded && len_ok) begin
            len_d   = iMsg_len;
            wkey_d  = store_key;
            kidx_d  = '0;
            beat_d  = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_fire) out_valid_d = 1'b0;
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = iIn_data ^ wkey_w[kidx_q];
          first_d     = (beat_q == '0);
          last_d      = (beat_q == len_q - LEN_W'(1));
          beat_d      = beat_q + LEN_W'(1);
          if (kidx_q == KCNT_W'(KEY_WORDS - 1)) begin
            kidx_d = '0;
`ifdef XOR_KEY_EVOLVE_EN
            wkey_d = KEY_BITS'(rotl1(ROT_MAX_W'(wkey_q), KEY_BITS));
`endif
          end else begin
            kidx_d = kidx_q + KCNT_W'(1);
          end
          if (beat_q == len_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; everything freezes while iEn is low.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      kidx_q      <= '0;
      wkey_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else if (iEn) begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      kidx_q      <= kidx_d;
      wkey_q      <= wkey_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      first_q     <= first_d;
      last_q      <= last_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign oKey_loaded = key_loaded;
  assign oErr        = err_q;
  assign oOut_valid  = out_valid_q;
  assign oOut_data   = out_data_q;
  assign oFirst      = first_q;
  assign oLast       = last_q;
  assign oDone       = done_q;

endmodule
